// File: rtl/sub_pipe.sv
// Pipelined subtract/compare unit.
// Two register stages share one advance enable. S1 registers the operands.
// S2 registers the selected result, the flags and |a-b|.
// A running peak of |a-b| is kept over delivered results for sensor-delta monitoring.
module sub_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             borrow,
  output logic             zero,
  input  logic             peak_clr,
  output logic [WIDTH-1:0] peak
);

  typedef enum logic [1:0] {
    ModeWrap = 2'b00,
    ModeSat  = 2'b01,
    ModeAbs  = 2'b10,
    ModeMin  = 2'b11
  } mode_e;

  // Shared advance enable: both stages move together or both hold.
  logic adv;

  // Stage 1: captured operands.
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  mode_e            s1_mode_q;

  // Stage 1 combinational result.
  logic [WIDTH:0]   s1_diff;
  logic             s1_borrow;
  logic [WIDTH-1:0] s1_abs;
  logic [WIDTH-1:0] s1_res;
  logic             s1_zero;

  // Stage 2: registered result, flags and |a-b| for the peak tracker.
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_res_q;
  logic             s2_borrow_q;
  logic             s2_zero_q;
  logic [WIDTH-1:0] s2_abs_q;

  // Peak tracker.
  logic             out_hs;
  logic [WIDTH-1:0] peak_d;
  logic [WIDTH-1:0] peak_q;

  // Advance whenever S2 is empty or its result is being taken.
  always_comb begin
    adv      = !s2_valid_q || out_ready;
    in_ready = adv;
  end

  // S1 register: operands load only on an accept; the valid bit follows in_valid on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_mode_q  <= ModeWrap;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q    <= a;
        s1_b_q    <= b;
        s1_mode_q <= mode_e'(mode);
      end
    end
  end

  // Subtract with one extra bit so the borrow falls out as the MSB.
  always_comb begin
    s1_diff   = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    s1_borrow = s1_diff[WIDTH];
    s1_abs    = s1_borrow ? (s1_b_q - s1_a_q) : s1_diff[WIDTH-1:0];
  end

  // Result select by the captured mode; zero is taken on the final result.
  always_comb begin
    s1_res = s1_diff[WIDTH-1:0];
    unique case (s1_mode_q)
      ModeWrap: s1_res = s1_diff[WIDTH-1:0];
      ModeSat:  s1_res = s1_borrow ? '0 : s1_diff[WIDTH-1:0];
      ModeAbs:  s1_res = s1_abs;
      ModeMin:  s1_res = s1_borrow ? s1_a_q : s1_b_q;
      default:  s1_res = s1_diff[WIDTH-1:0];
    endcase
    s1_zero = (s1_res == '0);
  end

  // S2 register: holds result and flags stable while the output stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      s2_res_q    <= '0;
      s2_borrow_q <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_abs_q    <= '0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_res_q    <= s1_res;
        s2_borrow_q <= s1_borrow;
        s2_zero_q   <= s1_zero;
        s2_abs_q    <= s1_abs;
      end
    end
  end

  // Peak next-state: a clear applies before the load of a result delivered in the same cycle.
  always_comb begin
    out_hs = s2_valid_q && out_ready;
    peak_d = peak_q;
    if (out_hs && peak_clr) begin
      peak_d = s2_abs_q;
    end else if (out_hs && (s2_abs_q > peak_q)) begin
      peak_d = s2_abs_q;
    end else if (peak_clr) begin
      peak_d = '0;
    end
  end

  // Peak register.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  // Output drive straight from registers.
  always_comb begin
    out_valid = s2_valid_q;
    q         = s2_res_q;
    borrow    = s2_borrow_q;
    zero      = s2_zero_q;
    peak      = peak_q;
  end

endmodule

// File: tb/tb_sub_pipe.sv
// Self-checking bench for sub_pipe.
// It applies directed table vectors, hand-written corner sequences and randomized
// traffic. The random traffic is checked against a queue-based reference model.
module tb_sub_pipe;

  localparam int W  = 8;
  localparam int XW = 16;

  typedef struct {
    int q;
    bit br;
    bit z;
    int ad;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   mode;
    logic [W-1:0] q;
    logic         br;
    logic         z;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, borrow, zero, peak_clr;
  logic [W-1:0] a, b, q, peak;
  logic [1:0]   mode;

  logic          x_in_valid, x_in_ready, x_out_valid, x_out_ready, x_borrow, x_zero, x_peak_clr;
  logic [XW-1:0] x_a, x_b, x_q, x_peak;
  logic [1:0]    x_mode;

  sub_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .q(q), .borrow(borrow),
    .zero(zero), .peak_clr(peak_clr), .peak(peak)
  );

  sub_pipe #(.WIDTH(XW)) dut16 (
    .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(x_in_ready), .a(x_a), .b(x_b),
    .mode(x_mode), .out_valid(x_out_valid), .out_ready(x_out_ready), .q(x_q),
    .borrow(x_borrow), .zero(x_zero), .peak_clr(x_peak_clr), .peak(x_peak)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   got[$];
  int   pk = 0;
  bit   last_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input int w, input int ia, input int ib, input int m);
    exp_t e;
    int   md;
    md   = 1 << w;
    e.br = (ia < ib);
    e.ad = e.br ? (ib - ia) : (ia - ib);
    case (m)
      0:       e.q = (ia - ib + md) % md;
      1:       e.q = e.br ? 0 : (ia - ib);
      2:       e.q = e.ad;
      default: e.q = (ia < ib) ? ia : ib;
    endcase
    e.z = (e.q == 0);
    return e;
  endfunction

  // One clock cycle. The caller drives inputs at the negedge; this task samples just after,
  // updates the model across the posedge, and returns at the next negedge.
  task automatic step();
    bit           hs, stall, was_rst;
    logic [W-1:0] hq;
    logic         hb, hz;
    exp_t         e;
    #1;
    was_rst  = rst;
    last_acc = in_valid && in_ready && !rst;
    hs       = out_valid && out_ready;
    stall    = out_valid && !out_ready && !rst;
    hq = q; hb = borrow; hz = zero;
    check("in_ready_rule", in_ready, !out_valid || out_ready);
    if (rst) begin
      sb.delete();
      pk = 0;
    end else begin
      if (hs) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got q=0x%0h, expected no output", q);
        end else begin
          e = sb.pop_front();
          check("sb_q", q, e.q);
          check("sb_borrow", borrow, e.br);
          check("sb_zero", zero, e.z);
          got.push_back(int'(q));
          if (peak_clr) pk = e.ad;
          else if (e.ad > pk) pk = e.ad;
        end
      end else if (peak_clr) begin
        pk = 0;
      end
      if (last_acc) sb.push_back(model(W, int'(a), int'(b), int'(mode)));
    end
    @(posedge clk);
    @(negedge clk);
    check("peak", peak, pk);
    if (stall) begin
      check("stall_out_valid", out_valid, 1);
      check("stall_q_held", q, hq);
      check("stall_borrow_held", borrow, hb);
      check("stall_zero_held", zero, hz);
    end
    if (was_rst) begin
      check("reset_out_valid", out_valid, 0);
      check("reset_q", q, 0);
      check("reset_flags", {borrow, zero}, 2'b00);
      check("reset_in_ready", in_ready, 1);
    end
  endtask

  initial begin
    vec_t tbl[12];
    int   pexp[3];
    int   sent;
    int   xpk;
    exp_t xq[$];
    exp_t e;

    tbl[0]  = '{8'h03, 8'h05, 2'd0, 8'hFE, 1'b1, 1'b0};
    tbl[1]  = '{8'h10, 8'h30, 2'd1, 8'h00, 1'b1, 1'b1};
    tbl[2]  = '{8'h10, 8'h30, 2'd2, 8'h20, 1'b1, 1'b0};
    tbl[3]  = '{8'h10, 8'h30, 2'd3, 8'h10, 1'b1, 1'b0};
    tbl[4]  = '{8'h30, 8'h10, 2'd0, 8'h20, 1'b0, 1'b0};
    tbl[5]  = '{8'h30, 8'h10, 2'd1, 8'h20, 1'b0, 1'b0};
    tbl[6]  = '{8'h30, 8'h10, 2'd3, 8'h10, 1'b0, 1'b0};
    tbl[7]  = '{8'h42, 8'h42, 2'd0, 8'h00, 1'b0, 1'b1};
    tbl[8]  = '{8'h42, 8'h42, 2'd3, 8'h42, 1'b0, 1'b0};
    tbl[9]  = '{8'h00, 8'hFF, 2'd2, 8'hFF, 1'b1, 1'b0};
    tbl[10] = '{8'hFF, 8'h00, 2'd0, 8'hFF, 1'b0, 1'b0};
    tbl[11] = '{8'h00, 8'h01, 2'd1, 8'h00, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = 2'd0; out_ready = 1'b1;
    peak_clr = 1'b0;
    x_in_valid = 1'b0; x_a = '0; x_b = '0; x_mode = 2'd0; x_out_ready = 1'b1;
    x_peak_clr = 1'b0;
    repeat (2) @(negedge clk);
    step();
    rst = 1'b0;
    check("init_out_valid", out_valid, 0);
    check("init_peak", peak, 0);
    check("init_in_ready", in_ready, 1);

    // 16-bit instance: directed extreme case then random stream at full throughput.
    xpk = 0;
    for (int j = 0; j <= 201; j++) begin
      if (j < 201) begin
        x_in_valid = 1'b1;
        if (j == 0) begin
          x_a = 16'h0000; x_b = 16'hFFFF; x_mode = 2'd2;
        end else begin
          x_a = 16'($urandom); x_b = 16'($urandom); x_mode = 2'($urandom_range(0, 3));
        end
        xq.push_back(model(XW, int'(x_a), int'(x_b), int'(x_mode)));
      end else begin
        x_in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (j >= 1) begin
        e = xq.pop_front();
        if (e.ad > xpk) xpk = e.ad;
        check("w16_valid", x_out_valid, 1);
        check("w16_q", x_q, e.q);
        check("w16_borrow", x_borrow, e.br);
        check("w16_zero", x_zero, e.z);
        if (j == 1) begin
          check("w16_abs_extreme_q", x_q, 16'hFFFF);
          check("w16_abs_extreme_borrow", x_borrow, 1);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("w16_peak", x_peak, xpk);

    // Table vectors streamed back to back: two-cycle latency, one result per cycle.
    for (int j = 0; j <= 12; j++) begin
      if (j < 12) begin
        in_valid = 1'b1; a = tbl[j].a; b = tbl[j].b; mode = tbl[j].mode;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (j == 0) check("latency_bubble", out_valid, 0);
      if (j == 2) check("wrap_peak", peak, 2);
      if (j >= 1) begin
        check("tbl_valid", out_valid, 1);
        check("tbl_q", q, tbl[j-1].q);
        check("tbl_borrow", borrow, tbl[j-1].br);
        check("tbl_zero", zero, tbl[j-1].z);
      end
    end
    step();

    // Backpressure: out_ready low for three cycles mid-stream.
    got.delete();
    sent = 0;
    for (int k = 0; k < 20; k++) begin
      in_valid  = (sent < 4);
      a         = 8'd50;
      b         = 8'(sent);
      mode      = 2'd0;
      out_ready = !(k >= 3 && k < 6);
      #1;
      if (k >= 3 && k < 6) check("stall_in_ready", in_ready, 0);
      step();
      if (last_acc) sent++;
    end
    out_ready = 1'b1;
    check("bp_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("bp_order", got[i], 50 - i);

    // Peak tracker: deltas 7, 200, 9, then clear with and without a handshake.
    in_valid = 1'b0; peak_clr = 1'b1;
    step();
    peak_clr = 1'b0;
    check("peak_clr_start", peak, 0);
    pexp[0] = 7; pexp[1] = 200; pexp[2] = 200;
    for (int j = 0; j < 5; j++) begin
      in_valid = (j < 3);
      case (j)
        0:       begin a = 8'd7;  b = 8'd0;   mode = 2'd0; end
        1:       begin a = 8'd0;  b = 8'd200; mode = 2'd2; end
        default: begin a = 8'd20; b = 8'd11;  mode = 2'd3; end
      endcase
      step();
      if (j >= 2) check("peak_seq", peak, pexp[j-2]);
    end
    in_valid = 1'b1; a = 8'd9; b = 8'd0; mode = 2'd1;
    step();
    in_valid = 1'b0;
    step();
    check("peak_clr_hs_valid", out_valid, 1);
    peak_clr = 1'b1;
    step();
    peak_clr = 1'b0;
    check("peak_clr_with_hs", peak, 9);
    peak_clr = 1'b1;
    step();
    peak_clr = 1'b0;
    check("peak_clr_alone", peak, 0);

    // Reset with two results in flight.
    in_valid = 1'b1; a = 8'd100; b = 8'd1; mode = 2'd0;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("pre_reset_peak", peak, 99);
    in_valid = 1'b1; a = 8'd5; b = 8'd60; mode = 2'd2;
    step();
    a = 8'd6; b = 8'd70;
    step();
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_peak", peak, 0);
    check("rst_mid_in_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      check("flush_no_output", out_valid, 0);
    end

    // Randomized traffic against the scoreboard.
    for (int n = 0; n < 10000; n++) begin
      rst       = ($urandom_range(0, 999) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      peak_clr  = ($urandom_range(0, 19) == 0);
      a         = 8'($urandom);
      b         = ($urandom_range(0, 7) == 0) ? a : 8'($urandom);
      mode      = 2'($urandom_range(0, 3));
      step();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; peak_clr = 1'b0;
    repeat (3) step();
    check("drain_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
